// File: rtl/load_store_unit.sv
// Load/store unit: memory stage after the ALU. Drives a req/gnt/rvalid data
// memory handshake, builds byte enables and replicated store lanes, and
// extends load data for writeback. Holds the pipeline while a request is open.
// Optional build macro LSU_TIMEOUT_EN adds a gnt/rvalid watchdog that
// returns to IDLE and pulses bus_error after TIMEOUT_CYCLES cycles.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  f3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        stall_q, stall_d;
    logic        ready_q, ready_d;
    logic        misal_q, misal_d;
    logic        berr_q, berr_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 8) ? 8 : CNT_W_RAW;
    localparam int unsigned LIMIT     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_c;
`endif

    logic        op_c;
    logic        fault_c;
    logic [3:0]  lane_be_c;
    logic [31:0] lane_wdata_c;
    logic [31:0] shifted_c;
    logic [31:0] load_ext_c;

    // Decode the incoming op: fault detection and store lane formation
    always_comb begin
        op_c    = ex_valid && (mem_read || mem_write);
        fault_c = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) fault_c = 1'b1;
        if (f3[1:0] == 2'b01 && alu_result[0])            fault_c = 1'b1;
        if (f3[1:0] == 2'b10 && alu_result[1:0] != 2'b00) fault_c = 1'b1;
        if (mem_read && mem_write)                        fault_c = 1'b1;

        lane_be_c    = 4'b1111;
        lane_wdata_c = store_data;
        case (f3[1:0])
            2'b00: begin
                lane_be_c    = 4'b0001 << alu_result[1:0];
                lane_wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                lane_be_c    = 4'b0011 << alu_result[1:0];
                lane_wdata_c = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Align returned word to the addressed byte and extend per funct3
    always_comb begin
        shifted_c = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b100:  load_ext_c = {24'h000000, shifted_c[7:0]};
            3'b001:  load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b101:  load_ext_c = {16'h0000, shifted_c[15:0]};
            default: load_ext_c = dmem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        misal_d    = 1'b0;
        berr_d     = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        expired_c  = (cnt_q == CNT_W'(LIMIT));
`endif

        case (state_q)
            IDLE: begin
                if (op_c) begin
                    if (fault_c) begin
                        misal_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        we_d    = mem_write;
                        addr_d  = {alu_result[31:2], 2'b00};
                        off_d   = alu_result[1:0];
                        wdata_d = lane_wdata_c;
                        be_d    = mem_write ? lane_be_c : 4'b1111;
                        f3_d    = f3;
                        rd_d    = rd_addr;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d = we_q ? IDLE : WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (expired_c) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = (rd_q != 5'd0);
                    wb_data_d  = load_ext_c;
                    wb_rd_d    = rd_q;
`ifdef LSU_TIMEOUT_EN
                end else if (expired_c) begin
                    state_d = IDLE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        req_d   = (state_d == REQ);
        stall_d = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            stall_q    <= 1'b0;
            ready_q    <= 1'b1;
            misal_q    <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            stall_q    <= stall_d;
            ready_q    <= ready_d;
            misal_q    <= misal_d;
            berr_q     <= berr_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Watchdog counter for the open request
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ex_ready   = ready_q;
    assign stall      = stall_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign misaligned = misal_q;
    assign bus_error  = berr_q;

endmodule
